// File: rtl/spi_out_pkg.sv
// Shared types and constants for the spi_out SPI frame transmitter.
package spi_out_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int BIT_IDX_W          = 5;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SHIFT,
        TAIL,
        GAP
    } state_e;

endpackage

// File: rtl/spi_out_if.sv
// Frame-buffer, request and SPI pin bundle for spi_out.
// rx_data/rx_valid exist only when SPI_OUT_MISO_CAPTURE_EN is defined.
interface spi_out_if #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = spi_out_pkg::DEFAULT_DATA_WIDTH
);

    logic                  start;
    logic [ADDR_WIDTH-1:0] base_address;
    logic [ADDR_WIDTH:0]   frame_count;
    logic [ADDR_WIDTH-1:0] read_address;
    logic                  read_strobe;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  busy;
    logic                  done;
    logic                  cs;
    logic                  sck;
    logic                  mosi;
    logic                  miso;

`ifdef SPI_OUT_MISO_CAPTURE_EN
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;

    modport master (
        input  start, base_address, frame_count, read_data, miso,
        output read_address, read_strobe, busy, done, cs, sck, mosi, rx_data, rx_valid
    );
    modport slave (
        output start, base_address, frame_count, read_data, miso,
        input  read_address, read_strobe, busy, done, cs, sck, mosi, rx_data, rx_valid
    );
`else
    modport master (
        input  start, base_address, frame_count, read_data, miso,
        output read_address, read_strobe, busy, done, cs, sck, mosi
    );
    modport slave (
        output start, base_address, frame_count, read_data, miso,
        input  read_address, read_strobe, busy, done, cs, sck, mosi
    );
`endif

endinterface

// File: rtl/spi_sck_gen.sv
// SCK generator: CLK_DIV clocks per half-period, held low while run is low.
// rise_tick/fall_tick are high in the cycle whose closing edge toggles sck.
module spi_sck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic run,
    output logic sck,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sck_q, sck_d;
    logic             half_end;

    always_comb begin
        half_end  = (cnt_q == CNT_W'(CLK_DIV - 1));
        rise_tick = run && half_end && !sck_q;
        fall_tick = run && half_end && sck_q;
        cnt_d     = cnt_q;
        sck_d     = sck_q;
        if (!run) begin
            cnt_d = '0;
            sck_d = 1'b0;
        end else if (half_end) begin
            cnt_d = '0;
            sck_d = !sck_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sck_q <= sck_d;
        end
    end

    assign sck = sck_q;

endmodule

// File: rtl/spi_out.sv
// Mode-0 MSB-first SPI transmitter streaming DATA_WIDTH-bit frames from a word memory.
// Optional SPI_OUT_MISO_CAPTURE_EN adds MISO capture on rx_data/rx_valid.
module spi_out
    import spi_out_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = 13
) (
    input  logic      clock,
    input  logic      reset_n,
    spi_out_if.master bus
);

    localparam int                      WAIT_W    = $clog2(2 * CLK_DIV) + 1;
    localparam logic [BIT_IDX_W-1:0]    LAST_BIT  = BIT_IDX_W'(DATA_WIDTH - 1);
    localparam logic [ADDR_WIDTH:0]     ONE_FRAME = (ADDR_WIDTH + 1)'(1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   frames_q, frames_d;
    logic [BIT_IDX_W-1:0]  bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  fetch_pend_q, fetch_pend_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic                  cs_q, cs_d;
    logic                  mosi_q, mosi_d;
    logic                  done_q, done_d;
    logic                  prefetch;
    logic                  sck, rise_tick, fall_tick;

    spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
        .clock     (clock),
        .reset_n   (reset_n),
        .run       (state_q == SHIFT),
        .sck       (sck),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    // addr_q always holds the next word to fetch; the next frame is prefetched on its LSB rise.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        frames_d     = frames_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        fetch_pend_d = 1'b0;
        wait_d       = wait_q;
        cs_d         = cs_q;
        mosi_d       = mosi_q;
        done_d       = 1'b0;
        prefetch     = (state_q == SHIFT) && rise_tick && (bit_q == LAST_BIT) && (frames_q > ONE_FRAME);
        if (fetch_pend_q) hold_d = bus.read_data;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.frame_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        addr_d   = bus.base_address;
                        frames_d = bus.frame_count;
                        state_d  = FETCH;
                    end
                end
            end
            FETCH: begin
                addr_d  = addr_q + 1'b1;
                state_d = LOAD;
            end
            LOAD: begin
                shift_d = bus.read_data;
                mosi_d  = bus.read_data[DATA_WIDTH-1];
                cs_d    = 1'b0;
                bit_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (prefetch) begin
                    addr_d       = addr_q + 1'b1;
                    fetch_pend_d = 1'b1;
                end
                if (fall_tick) begin
                    if (bit_q != LAST_BIT) begin
                        shift_d = shift_q << 1;
                        mosi_d  = shift_q[DATA_WIDTH-2];
                        bit_d   = bit_q + 1'b1;
                    end else if (frames_q > ONE_FRAME) begin
                        shift_d  = hold_q;
                        mosi_d   = hold_q[DATA_WIDTH-1];
                        bit_d    = '0;
                        frames_d = frames_q - 1'b1;
                    end else begin
                        mosi_d  = 1'b0;
                        wait_d  = '0;
                        state_d = TAIL;
                    end
                end
            end
            TAIL: begin
                wait_d = wait_q + 1'b1;
                if (wait_q == WAIT_W'(CLK_DIV - 1)) begin
                    cs_d    = 1'b1;
                    wait_d  = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                wait_d = wait_q + 1'b1;
                if (wait_q == WAIT_W'(2 * CLK_DIV - 1)) begin
                    wait_d  = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            frames_q     <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            hold_q       <= '0;
            fetch_pend_q <= 1'b0;
            wait_q       <= '0;
            cs_q         <= 1'b1;
            mosi_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            frames_q     <= frames_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            fetch_pend_q <= fetch_pend_d;
            wait_q       <= wait_d;
            cs_q         <= cs_d;
            mosi_q       <= mosi_d;
            done_q       <= done_d;
        end
    end

    assign bus.read_address = addr_q;
    assign bus.read_strobe  = (state_q == FETCH) || prefetch;
    assign bus.busy         = (state_q != IDLE);
    assign bus.done         = done_q;
    assign bus.cs           = cs_q;
    assign bus.sck          = sck;
    assign bus.mosi         = mosi_q;

`ifdef SPI_OUT_MISO_CAPTURE_EN
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;

    always_comb begin
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        if (rise_tick) begin
            rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], bus.miso};
            if (bit_q == LAST_BIT) begin
                rx_data_d  = {rx_shift_q[DATA_WIDTH-2:0], bus.miso};
                rx_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
`endif

endmodule

// File: tb/tb_spi_out.sv
// Self-checking bench for spi_out: a word memory feeds the DUT and a pin monitor
// rebuilds the SPI bit stream, compared against words computed from the memory contents.
module tb_spi_out;

    localparam int CLK_DIV = 4;
    localparam int AW      = 13;
    localparam int DW      = 16;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    spi_out_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    spi_out #(.CLK_DIV(CLK_DIV), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Synchronous frame buffer; read_data is garbage except the cycle after a strobe.
    always @(posedge clock) begin
        if (bus.read_strobe) bus.read_data <= mem[bus.read_address];
        else                 bus.read_data <= DW'($urandom);
    end

    int n_checks = 0;
    int n_pass   = 0;

    int      rd_q[$];
    logic    bits_q[$];
    int      rises, cs_windows, cs_low, done_cnt, done_cycle, first_cs_low;
    int      busy_cycles, gap_err, sck_err, rx_pulses;
    bit      timed_out;
    logic [DW-1:0] rx_last;
    logic    post_cs, post_sck, post_busy, post_done, post_strobe;

    function automatic logic [DW-1:0] got_word(input int f);
        logic [DW-1:0] w;
        w = '0;
        for (int b = 0; b < DW; b++)
            if (DW * f + b < bits_q.size()) w = {w[DW-2:0], bits_q[DW*f+b]};
        return w;
    endfunction

    function automatic int exp_done(input int cnt);
        return 3 + 32 * CLK_DIV * cnt + 3 * CLK_DIV;
    endfunction

    task automatic run_burst(input logic [AW-1:0] base, input logic [AW:0] cnt,
                             input int rst_rise, input int start_rise, input logic [DW-1:0] miso_word);
        int cycles, last_rise, budget, tail;
        logic prev_sck, prev_cs, prev_mosi;
        logic [3:0] mi;
        bit extra;
        rd_q.delete();
        bits_q.delete();
        rises = 0; cs_windows = 0; cs_low = 0; done_cnt = 0; done_cycle = -1; first_cs_low = -1;
        busy_cycles = 0; gap_err = 0; sck_err = 0; rx_pulses = 0; rx_last = '0; timed_out = 0;
        last_rise = -1; tail = -1; extra = 0; mi = '0;
        budget = int'(cnt) * 32 * CLK_DIV + 20 * CLK_DIV + 50;
        prev_sck = bus.sck; prev_cs = bus.cs; prev_mosi = bus.mosi;
        bus.base_address = base;
        bus.frame_count  = cnt;
        bus.start        = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        cycles = 1;
        forever begin
            if (bus.read_strobe) rd_q.push_back(int'(bus.read_address));
            if (bus.busy) busy_cycles++;
            if (bus.sck && bus.cs) sck_err++;
            if (!bus.cs) begin
                cs_low++;
                if (prev_cs) begin
                    cs_windows++;
                    if (first_cs_low < 0) first_cs_low = cycles;
                    bus.miso = miso_word[15];
                    mi = 4'd1;
                end
            end
            if (bus.sck && !prev_sck) begin
                rises++;
                bits_q.push_back(prev_mosi);
                if (last_rise >= 0 && cycles - last_rise != 2 * CLK_DIV) gap_err++;
                last_rise = cycles;
            end
            if (!bus.sck && prev_sck) begin
                bus.miso = miso_word[4'd15 - mi];
                mi++;
            end
`ifdef SPI_OUT_MISO_CAPTURE_EN
            if (bus.rx_valid) begin
                rx_pulses++;
                rx_last = bus.rx_data;
            end
`endif
            if (bus.done) begin
                done_cnt++;
                if (done_cycle < 0) done_cycle = cycles;
            end
            if (done_cycle >= 0 && tail < 0) tail = 2 * CLK_DIV + 4;
            if (rst_rise >= 0 && rises == rst_rise) begin
                reset_n = 1'b0;
                @(posedge clock); #1;
                post_cs = bus.cs; post_sck = bus.sck; post_busy = bus.busy;
                post_done = bus.done; post_strobe = bus.read_strobe;
                reset_n = 1'b1;
                return;
            end
            if (start_rise >= 0 && rises == start_rise && !extra) begin
                bus.base_address = AW'($urandom);
                bus.frame_count  = (AW + 1)'($urandom_range(1, 5));
                bus.start        = 1'b1;
                extra            = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            prev_sck = bus.sck; prev_cs = bus.cs; prev_mosi = bus.mosi;
            if (tail == 0) break;
            if (tail > 0) tail--;
            if (cycles >= budget) begin
                timed_out = 1'b1;
                break;
            end
            @(posedge clock); #1;
            cycles++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.start = 1'b0; bus.base_address = '0; bus.frame_count = '0; bus.miso = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        n_checks++; if (bus.cs !== 1'b1) $display("[TB] FAIL reset_cs: got %b want 1", bus.cs); else n_pass++;
        n_checks++; if (bus.sck !== 1'b0) $display("[TB] FAIL reset_sck: got %b want 0", bus.sck); else n_pass++;
        n_checks++; if (bus.mosi !== 1'b0) $display("[TB] FAIL reset_mosi: got %b want 0", bus.mosi); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
        n_checks++; if (bus.done !== 1'b0) $display("[TB] FAIL reset_done: got %b want 0", bus.done); else n_pass++;
        n_checks++; if (bus.read_strobe !== 1'b0) $display("[TB] FAIL reset_strobe: got %b want 0", bus.read_strobe); else n_pass++;
        n_checks++; if (bus.read_address !== '0) $display("[TB] FAIL reset_addr: got %0h want 0", bus.read_address); else n_pass++;
`ifdef SPI_OUT_MISO_CAPTURE_EN
        n_checks++; if (bus.rx_data !== '0 || bus.rx_valid !== 1'b0) $display("[TB] FAIL reset_rx: got %0h/%b want 0/0", bus.rx_data, bus.rx_valid); else n_pass++;
`endif
        reset_n = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_single_frame();
        mem[5] = 16'hA5C3;
        run_burst(13'h005, 14'd1, -1, -1, 16'h0000);
        n_checks++; if (timed_out) $display("[TB] FAIL single_timeout: got timeout want done"); else n_pass++;
        n_checks++; if (rd_q.size() !== 1) $display("[TB] FAIL single_reads: got %0d want 1", rd_q.size()); else n_pass++;
        n_checks++; if (rd_q.size() > 0 && rd_q[0] !== 5) $display("[TB] FAIL single_addr: got %0h want 5", rd_q[0]); else n_pass++;
        n_checks++; if (rises !== 16) $display("[TB] FAIL single_rises: got %0d want 16", rises); else n_pass++;
        n_checks++; if (got_word(0) !== 16'hA5C3) $display("[TB] FAIL single_word: got %h want a5c3", got_word(0)); else n_pass++;
        n_checks++; if (cs_windows !== 1) $display("[TB] FAIL single_cs_windows: got %0d want 1", cs_windows); else n_pass++;
        n_checks++; if (cs_low !== 33 * CLK_DIV) $display("[TB] FAIL single_cs_low: got %0d want %0d", cs_low, 33 * CLK_DIV); else n_pass++;
        n_checks++; if (first_cs_low !== 3) $display("[TB] FAIL single_latency: got %0d want 3", first_cs_low); else n_pass++;
        n_checks++; if (done_cnt !== 1) $display("[TB] FAIL single_done_cnt: got %0d want 1", done_cnt); else n_pass++;
        n_checks++; if (done_cycle !== exp_done(1)) $display("[TB] FAIL single_done_cycle: got %0d want %0d", done_cycle, exp_done(1)); else n_pass++;
        n_checks++; if (busy_cycles !== exp_done(1) - 1) $display("[TB] FAIL single_busy: got %0d want %0d", busy_cycles, exp_done(1) - 1); else n_pass++;
        n_checks++; if (gap_err !== 0 || sck_err !== 0) $display("[TB] FAIL single_sck: got gap %0d cs-high %0d want 0 0", gap_err, sck_err); else n_pass++;
    endtask

    task automatic test_wrap_burst();
        mem[13'h1FFE] = 16'h1111; mem[13'h1FFF] = 16'h2222; mem[13'h0000] = 16'h3333;
        run_burst(13'h1FFE, 14'd3, -1, -1, 16'h0000);
        n_checks++; if (rd_q.size() !== 3) $display("[TB] FAIL wrap_reads: got %0d want 3", rd_q.size()); else n_pass++;
        for (int i = 0; i < 3 && i < rd_q.size(); i++) begin
            n_checks++; if (rd_q[i] !== int'(AW'(13'h1FFE + i))) $display("[TB] FAIL wrap_addr%0d: got %0h want %0h", i, rd_q[i], AW'(13'h1FFE + i)); else n_pass++;
        end
        n_checks++; if (rises !== 48) $display("[TB] FAIL wrap_rises: got %0d want 48", rises); else n_pass++;
        for (int f = 0; f < 3; f++) begin
            n_checks++; if (got_word(f) !== mem[AW'(13'h1FFE + f)]) $display("[TB] FAIL wrap_word%0d: got %h want %h", f, got_word(f), mem[AW'(13'h1FFE + f)]); else n_pass++;
        end
        n_checks++; if (cs_windows !== 1 || gap_err !== 0) $display("[TB] FAIL wrap_continuous: got windows %0d gaps %0d want 1 0", cs_windows, gap_err); else n_pass++;
        n_checks++; if (done_cycle !== exp_done(3) || done_cnt !== 1) $display("[TB] FAIL wrap_done: got cycle %0d cnt %0d want %0d 1", done_cycle, done_cnt, exp_done(3)); else n_pass++;
    endtask

    task automatic test_zero_count();
        run_burst(13'h0123, 14'd0, -1, -1, 16'h0000);
        n_checks++; if (done_cycle !== 1 || done_cnt !== 1) $display("[TB] FAIL zero_done: got cycle %0d cnt %0d want 1 1", done_cycle, done_cnt); else n_pass++;
        n_checks++; if (cs_windows !== 0 || rises !== 0 || rd_q.size() !== 0) $display("[TB] FAIL zero_activity: got cs %0d sck %0d reads %0d want 0 0 0", cs_windows, rises, rd_q.size()); else n_pass++;
        n_checks++; if (busy_cycles !== 0) $display("[TB] FAIL zero_busy: got %0d want 0", busy_cycles); else n_pass++;
    endtask

    task automatic test_reset_mid_burst();
        int d;
        d = 0;
        run_burst(13'h0100, 14'd2, 7, -1, 16'h0000);
        n_checks++; if (post_cs !== 1'b1 || post_sck !== 1'b0) $display("[TB] FAIL midreset_pins: got cs %b sck %b want 1 0", post_cs, post_sck); else n_pass++;
        n_checks++; if (post_busy !== 1'b0 || post_done !== 1'b0 || post_strobe !== 1'b0) $display("[TB] FAIL midreset_ctrl: got busy %b done %b strobe %b want 0 0 0", post_busy, post_done, post_strobe); else n_pass++;
        repeat (12 * CLK_DIV) begin
            @(posedge clock); #1;
            if (bus.done || !bus.cs || bus.sck) d++;
        end
        n_checks++; if (d !== 0) $display("[TB] FAIL midreset_quiet: got %0d active cycles want 0", d); else n_pass++;
        run_burst(13'h0100, 14'd1, -1, -1, 16'h0000);
        n_checks++; if (got_word(0) !== mem[13'h0100] || rises !== 16) $display("[TB] FAIL midreset_rerun: got %h/%0d want %h/16", got_word(0), rises, mem[13'h0100]); else n_pass++;
        n_checks++; if (done_cycle !== exp_done(1)) $display("[TB] FAIL midreset_done: got %0d want %0d", done_cycle, exp_done(1)); else n_pass++;
    endtask

    task automatic test_start_ignored();
        run_burst(13'h0A00, 14'd2, -1, 5, 16'h0000);
        n_checks++; if (rd_q.size() !== 2) $display("[TB] FAIL ignore_reads: got %0d want 2", rd_q.size()); else n_pass++;
        n_checks++; if (rd_q.size() == 2 && (rd_q[0] !== 13'h0A00 || rd_q[1] !== 13'h0A01)) $display("[TB] FAIL ignore_addr: got %0h %0h want a00 a01", rd_q[0], rd_q[1]); else n_pass++;
        n_checks++; if (rises !== 32 || got_word(1) !== mem[13'h0A01]) $display("[TB] FAIL ignore_frames: got %0d rises word1 %h want 32 %h", rises, got_word(1), mem[13'h0A01]); else n_pass++;
        n_checks++; if (done_cycle !== exp_done(2) || done_cnt !== 1) $display("[TB] FAIL ignore_done: got cycle %0d cnt %0d want %0d 1", done_cycle, done_cnt, exp_done(2)); else n_pass++;
    endtask

    task automatic test_random_bursts();
        logic [AW-1:0] base;
        int cnt;
        for (int it = 0; it < 4; it++) begin
            base = (it % 2 == 0) ? AW'($urandom) : AW'(13'h1FFF - $urandom_range(0, 2));
            cnt  = $urandom_range(1, 3);
            run_burst(base, (AW + 1)'(cnt), -1, -1, 16'h0000);
            n_checks++; if (rd_q.size() !== cnt || rises !== 16 * cnt) $display("[TB] FAIL rand%0d_counts: got %0d reads %0d rises want %0d %0d", it, rd_q.size(), rises, cnt, 16 * cnt); else n_pass++;
            for (int f = 0; f < cnt; f++) begin
                n_checks++; if (got_word(f) !== mem[AW'(base + f)]) $display("[TB] FAIL rand%0d_word%0d: got %h want %h", it, f, got_word(f), mem[AW'(base + f)]); else n_pass++;
            end
            n_checks++; if (done_cycle !== exp_done(cnt)) $display("[TB] FAIL rand%0d_done: got %0d want %0d", it, done_cycle, exp_done(cnt)); else n_pass++;
        end
    endtask

`ifdef SPI_OUT_MISO_CAPTURE_EN
    task automatic test_miso_capture();
        run_burst(13'h0042, 14'd1, -1, -1, 16'h5AF0);
        n_checks++; if (rx_pulses !== 1) $display("[TB] FAIL miso_pulses: got %0d want 1", rx_pulses); else n_pass++;
        n_checks++; if (rx_last !== 16'h5AF0) $display("[TB] FAIL miso_data: got %h want 5af0", rx_last); else n_pass++;
    endtask
`endif

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
        test_reset();
        test_single_frame();
        test_wrap_burst();
        test_zero_count();
        test_reset_mid_burst();
        test_start_ignored();
        test_random_bursts();
`ifdef SPI_OUT_MISO_CAPTURE_EN
        test_miso_capture();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: got no finish want finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/spi_out.md
Name: spi_out

Overview:
- SPI master transmitter in the system clock domain. It streams 16-bit frames from a word-addressed memory to an external SPI receiver.
- Mode 0, MSB first, one CS-low burst per request.
- Addresses auto-increment from a base address, so each frame's receiver-side address tracks the source address.
- Sits between a frame buffer (synchronous read port, 1-cycle latency) and the board SPI pins.

Parameters:
- CLK_DIV, 4, system clocks per SCK half-period; minimum 2.
- DATA_WIDTH, 16, bits per frame.
- ADDR_WIDTH, 13, memory address width.

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous reset, active-low
- start  in  1  1-cycle request; sampled only in IDLE
- base_address  in  ADDR_WIDTH  first word address; sampled with start
- frame_count  in  ADDR_WIDTH+1  frames to send; sampled with start
- read_address  out  ADDR_WIDTH  memory read address
- read_strobe  out  1  1-cycle read request
- read_data  in  DATA_WIDTH  memory word; valid the cycle after read_strobe
- busy  out  1  high from the cycle after start until return to IDLE
- done  out  1  1-cycle pulse at end of burst
- cs  out  1  SPI chip select, active-low
- sck  out  1  SPI clock, idle low
- mosi  out  1  SPI data out
- miso  in  1  SPI data in; used only with the optional feature

Behaviour:
- Reset (reset_n low at a clock edge):
  - cs=1, sck=0, mosi=0, busy=0, done=0, read_strobe=0, read_address=0.
  - State IDLE, counters cleared.
  - Applies mid-burst too: cs rises and sck returns low on the same edge, and no done pulse is produced.
- States and transitions:
  - IDLE, start=1, frame_count=0: done=1 next cycle; cs stays high, no reads.
  - IDLE, start=1, frame_count>0: latch base_address and frame_count, go to FETCH.
  - FETCH: read_strobe=1 with read_address=base; then go to LOAD.
  - LOAD: shift register <= read_data; cs=0; mosi=bit 15; go to SHIFT.
  - SHIFT: sck stays low for CLK_DIV cycles, then high for CLK_DIV cycles.
    - On each falling edge, shift the next bit onto mosi.
    - The receiver samples on rising edges, so mosi is stable CLK_DIV cycles before every rise.
  - After the 16th falling edge, with frames remaining: mosi is the MSB of the next word; sck continues without a gap; the next frame starts.
  - After the last frame's 16th falling edge: go to TAIL.
  - TAIL: cs held low with sck low for CLK_DIV cycles, then cs=1; go to GAP.
  - GAP: cs high for 2*CLK_DIV cycles, so the receiver re-arms its frame start. Then done=1 for one cycle, busy=0, back to IDLE.
- Prefetch of the next word:
  - read_strobe pulses for one cycle on the cycle sck rises for bit 0, with read_address incremented by 1.
  - The word lands in a holding register before the falling edge; CLK_DIV>=2 guarantees this.
- Address arithmetic: read_address wraps modulo 2^ADDR_WIDTH (max address + 1 -> 0).
- Timing:
  - SCK period is 2*CLK_DIV clocks.
  - Frame time is 32*CLK_DIV clocks.
  - Burst latency from start to first cs low is 3 clocks.
- Other boundaries:
  - start while busy is ignored.
  - read_data is sampled only in the cycle after read_strobe.
  - frame_count max is 2^ADDR_WIDTH; the full memory is sent once, wrapping back to base.

Optional Feature:
- Macro: SPI_OUT_MISO_CAPTURE_EN.
- Defined:
  - Adds outputs rx_data[DATA_WIDTH] and rx_valid.
  - miso is sampled on each sck rising edge, MSB first.
  - After each frame's 16th rising edge, rx_data updates and rx_valid pulses 1 cycle.
  - Both outputs reset to 0.
- Undefined: miso is ignored and the extra ports are absent.

Decomposition:
- Package spi_out_pkg holds:
  - the state enum (IDLE, FETCH, LOAD, SHIFT, TAIL, GAP);
  - the DATA_WIDTH default;
  - bit-index width constant of 5 bits.
- Sub-module spi_sck_gen:
  - CLK_DIV half-period counter;
  - outputs sck plus 1-cycle rise_tick and fall_tick;
  - run input, and sck forced low when run=0.

Test Plan:
- Single frame, CLK_DIV=4, base 0x005, mem[5]=0xA5C3:
  - exactly one read_strobe at address 0x005;
  - cs low for 16 sck periods plus the 4-clock tail;
  - mosi sampled at rises = 1010010111000011;
  - done pulses once.
- Burst of 3 frames from base 0x1FFE, memory 0x1111/0x2222/0x3333:
  - read addresses 0x1FFE, 0x1FFF, 0x0000;
  - 48 continuous sck pulses and a single cs-low window;
  - words received in order.
- frame_count=0: done pulses 1 cycle after start; cs, sck and read_strobe never toggle.
- Reset mid-burst after the 7th rising edge:
  - next clock cs=1, sck=0, busy=0, no done pulse;
  - a new start then sends the full frame correctly.
- start pulsed during SHIFT: ignored; frame count and addresses are unchanged.
- With SPI_OUT_MISO_CAPTURE_EN, miso driven with 0x5AF0 over one frame: rx_data=0x5AF0 and rx_valid pulses once after the 16th rise.
